// File: rtl/wb_pad_in.sv
// wb_pad_in: synchronizes, debounces and edge-detects NUM_PADS pads into sticky STATUS bits behind a Wishbone slave.
// Latency: ack/err 1 cycle after the first cyc&stb cycle; pad->deb D+2, ->STATUS +1, ->int_o +1 cycles.
// Backpressure: never stalls; one transfer per 2 cycles, master holds stb until ack/err.
module wb_pad_in #(
   parameter int NUM_PADS        = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WB_ADDR_WIDTH   = 32,
   parameter int WB_DATA_WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       s_cyc_i,
   input  logic                       s_stb_i,
   input  logic                       s_we_i,
   input  logic [WB_DATA_WIDTH/8-1:0] s_sel_i,
   input  logic [WB_ADDR_WIDTH-1:0]   s_adr_i,
   input  logic [WB_DATA_WIDTH-1:0]   s_dat_w_i,
   output logic [WB_DATA_WIDTH-1:0]   s_dat_r_o,
   output logic                       s_ack_o,
   output logic                       s_err_o,
   input  logic [NUM_PADS-1:0]        pad_i,
   output logic                       int_o
);

   typedef enum logic {S_IDLE, S_RESP} state_t;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_IE     = 2'd1;
   localparam logic [1:0] REG_EDGE   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   logic [NUM_PADS-1:0]        sync1_q, sync2_q, deb_q, deb_prev_q;
   logic [NUM_PADS-1:0]        ie_q, ie_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [NUM_PADS-1:0]        status_q, status_d, set_evt, clr;
   logic                       int_d;
   state_t                     state_q, state_d;
   logic                       we_q, adr_err_q, wr_act;
   logic [WB_DATA_WIDTH/8-1:0] sel_q;
   logic [1:0]                 reg_sel_q;
   logic [WB_DATA_WIDTH-1:0]   wdat_q, rdata_q, rd_mux;
   logic                       unused_ok;

   // Address bits outside the decoded window and unused write-data/lane bits.
   assign unused_ok = ^{s_adr_i, wdat_q, sel_q};

   // Two-flop synchronizer for the asynchronous pads.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= pad_i;
         sync2_q <= sync1_q;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_nodeb
         // Debouncer bypassed: deb is simply the synchronized level, registered.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) deb_q <= '0;
            else       deb_q <= sync2_q;
         end
      end else begin : g_deb
         localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
         logic [CW-1:0] cnt_q [NUM_PADS];

         // Per-pad stability counter; deb follows sync2 only after D consecutive differing cycles.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               deb_q <= '0;
               for (int i = 0; i < NUM_PADS; i++) cnt_q[i] <= '0;
            end else begin
               for (int i = 0; i < NUM_PADS; i++) begin
                  if (sync2_q[i] == deb_q[i]) begin
                     cnt_q[i] <= '0;
                  end else if (cnt_q[i] == CNT_LAST) begin
                     deb_q[i] <= sync2_q[i];
                     cnt_q[i] <= '0;
                  end else begin
                     cnt_q[i] <= cnt_q[i] + 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

   assign set_evt = (deb_q & ~deb_prev_q & rise_en_q) | (~deb_q & deb_prev_q & fall_en_q);
   assign wr_act  = (state_q == S_RESP) && we_q && !adr_err_q;

   // Register write decode, W1C and interrupt next state. New events reach int_o one
   // cycle after STATUS; clears and IE writes act on int_o in the cycle after the ack.
   always_comb begin
      ie_d      = ie_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      clr       = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (wr_act && reg_sel_q == REG_IE && sel_q[i/8])       ie_d[i]      = wdat_q[i];
         if (wr_act && reg_sel_q == REG_EDGE && sel_q[i/8])     rise_en_d[i] = wdat_q[i];
         if (wr_act && reg_sel_q == REG_EDGE && sel_q[2 + i/8]) fall_en_d[i] = wdat_q[16 + i];
         if (wr_act && reg_sel_q == REG_STATUS && sel_q[i/8])   clr[i]       = wdat_q[i];
      end
      status_d = set_evt | (status_q & ~clr);
      int_d    = |(status_q & status_d & ie_d);
   end

   // Control/status registers and the edge-detect history.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         deb_prev_q <= '0;
         ie_q       <= '0;
         rise_en_q  <= '0;
         fall_en_q  <= '0;
         status_q   <= '0;
         int_o      <= 1'b0;
      end else begin
         deb_prev_q <= deb_q;
         ie_q       <= ie_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         status_q   <= status_d;
         int_o      <= int_d;
      end
   end

   // Read mux, sampled when the request is accepted.
   always_comb begin
      rd_mux = '0;
      case (s_adr_i[3:2])
         REG_DATA:   rd_mux[NUM_PADS-1:0] = deb_q;
         REG_IE:     rd_mux[NUM_PADS-1:0] = ie_q;
         REG_EDGE: begin
            rd_mux[NUM_PADS-1:0]  = rise_en_q;
            rd_mux[16 +: NUM_PADS] = fall_en_q;
         end
         REG_STATUS: rd_mux[NUM_PADS-1:0] = status_q;
         default:    rd_mux = '0;
      endcase
   end

   // Bus FSM next state: RESP always returns to IDLE, so a held stb never acks twice in a row.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (s_cyc_i && s_stb_i) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Bus FSM state and request capture.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         we_q      <= 1'b0;
         sel_q     <= '0;
         wdat_q    <= '0;
         reg_sel_q <= '0;
         adr_err_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && s_cyc_i && s_stb_i) begin
            we_q      <= s_we_i;
            sel_q     <= s_sel_i;
            wdat_q    <= s_dat_w_i;
            reg_sel_q <= s_adr_i[3:2];
            adr_err_q <= |s_adr_i[11:4];
            rdata_q   <= (|s_adr_i[11:4]) ? '0 : rd_mux;
         end
      end
   end

   assign s_ack_o   = (state_q == S_RESP) && !adr_err_q;
   assign s_err_o   = (state_q == S_RESP) && adr_err_q;
   assign s_dat_r_o = rdata_q;

endmodule

// File: tb/tb_wb_pad_in.sv
// tb_wb_pad_in: directed bench for wb_pad_in (NUM_PADS=4, DEBOUNCE_CYCLES=16).
// Latency: each scenario task checks bus and pad-to-interrupt cycle timing inline.
// Backpressure: master holds stb until ack/err, bounded to 8 cycles per access.
module tb_wb_pad_in;
   logic        clk = 1'b0;
   logic        rstn;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_w, dat_r;
   logic        ack, err;
   logic [3:0]  pad;
   logic        int_o;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   wb_pad_in #(.NUM_PADS(4), .DEBOUNCE_CYCLES(16), .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) dut (
      .clk(clk), .rstn(rstn),
      .s_cyc_i(cyc), .s_stb_i(stb), .s_we_i(we), .s_sel_i(sel), .s_adr_i(adr),
      .s_dat_w_i(dat_w), .s_dat_r_o(dat_r), .s_ack_o(ack), .s_err_o(err),
      .pad_i(pad), .int_o(int_o)
   );

   // One bus access; lat = cycles between the first stb cycle and the response (99 on timeout).
   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] rd, output int lat, output logic got_err, output logic got_ack);
      logic got;
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
      lat = 0; got = 1'b0; rd = '0; got_err = 1'b0; got_ack = 1'b0;
      while (!got && lat < 8) begin
         @(negedge clk);
         if (ack || err) begin
            got = 1'b1; rd = dat_r; got_err = err; got_ack = ack;
         end else begin
            lat++;
         end
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got) lat = 99;
   endtask

   task automatic test_reset();
      logic [31:0] rd; int lat; logic ge, ga;
      rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; dat_w = '0; pad = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (ack !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_ackerr got=%b%b want=00", ack, err); end
      total++; if (dat_r !== 32'h0) begin bad++; $display("FAIL rst_datr got=%h want=0", dat_r); end
      total++; if (int_o !== 1'b0) begin bad++; $display("FAIL rst_int got=%b want=0", int_o); end
      @(negedge clk) rstn = 1'b1;
      for (int r = 0; r < 4; r++) begin
         wb_xfer(1'b0, 32'(r * 4), 32'h0, 4'hF, rd, lat, ge, ga);
         total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_read adr=%0h got=%h want=0", r * 4, rd); end
         total++; if (lat !== 1 || ga !== 1'b1) begin bad++; $display("FAIL rst_lat adr=%0h got=%0d/%b want=1/1", r * 4, lat, ga); end
      end
   endtask

   task automatic test_rising();
      logic [31:0] rd; int lat; logic ge, ga;
      wb_xfer(1'b1, 32'h4, 32'h1, 4'hF, rd, lat, ge, ga);
      wb_xfer(1'b1, 32'h8, 32'h1, 4'hF, rd, lat, ge, ga);
      @(posedge clk); #1;
      pad[0] = 1'b1;
      repeat (19) @(posedge clk);
      #1;
      total++; if (int_o !== 1'b0) begin bad++; $display("FAIL rise_int_early got=%b want=0 at t+19", int_o); end
      @(posedge clk); #1;
      total++; if (int_o !== 1'b1) begin bad++; $display("FAIL rise_int got=%b want=1 at t+20", int_o); end
      wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL rise_data got=%h want=1", rd); end
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL rise_status got=%h want=1", rd); end
      wb_xfer(1'b1, 32'hC, 32'h1, 4'hF, rd, lat, ge, ga);
      total++; if (int_o !== 1'b0) begin bad++; $display("FAIL w1c_int got=%b want=0", int_o); end
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c_status got=%h want=0", rd); end
      // Falling edge is not enabled here, so releasing the pad must not set STATUS.
      pad[0] = 1'b0;
      repeat (25) @(posedge clk);
      wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rise_release_data got=%h want=0", rd); end
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rise_release_status got=%h want=0", rd); end
   endtask

   task automatic test_glitch();
      logic [31:0] rd; int lat; logic ge, ga;
      wb_xfer(1'b1, 32'h8, 32'h000F000F, 4'hF, rd, lat, ge, ga);
      @(posedge clk); #1;
      pad[2] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      pad[2] = 1'b0;
      repeat (30) @(posedge clk);
      wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL glitch_data got=%h want=0", rd); end
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL glitch_status got=%h want=0", rd); end
      @(posedge clk); #1;
      pad[2] = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      pad[2] = 1'b0;
      repeat (30) @(posedge clk);
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h4) begin bad++; $display("FAIL long_pulse_status got=%h want=4", rd); end
      wb_xfer(1'b1, 32'hC, 32'hF, 4'hF, rd, lat, ge, ga);
   endtask

   task automatic test_fall_mask();
      logic [31:0] rd; int lat; logic ge, ga;
      wb_xfer(1'b1, 32'h8, 32'h00020000, 4'hF, rd, lat, ge, ga);
      wb_xfer(1'b1, 32'h4, 32'h0, 4'hF, rd, lat, ge, ga);
      pad[1] = 1'b1;
      repeat (25) @(posedge clk);
      wb_xfer(1'b1, 32'hC, 32'hF, 4'hF, rd, lat, ge, ga);
      pad[1] = 1'b0;
      repeat (25) @(posedge clk);
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h2) begin bad++; $display("FAIL fall_status got=%h want=2", rd); end
      total++; if (int_o !== 1'b0) begin bad++; $display("FAIL fall_masked_int got=%b want=0", int_o); end
      wb_xfer(1'b1, 32'h4, 32'h2, 4'hF, rd, lat, ge, ga);
      total++; if (int_o !== 1'b1) begin bad++; $display("FAIL ie_unmask_int got=%b want=1", int_o); end
      wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h2) begin bad++; $display("FAIL ie_readback got=%h want=2", rd); end
      // Byte lane 0 disabled: the W1C must be ignored.
      wb_xfer(1'b1, 32'hC, 32'h2, 4'hE, rd, lat, ge, ga);
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h2) begin bad++; $display("FAIL sel_gate_status got=%h want=2", rd); end
      wb_xfer(1'b1, 32'hC, 32'h2, 4'h1, rd, lat, ge, ga);
      total++; if (int_o !== 1'b0) begin bad++; $display("FAIL fall_w1c_int got=%b want=0", int_o); end
   endtask

   task automatic test_collision();
      logic [31:0] rd; int lat; logic ge, ga;
      wb_xfer(1'b1, 32'h8, 32'h8, 4'hF, rd, lat, ge, ga);
      wb_xfer(1'b1, 32'h4, 32'h8, 4'hF, rd, lat, ge, ga);
      @(posedge clk); #1;
      pad[3] = 1'b1;
      repeat (16) @(posedge clk);
      #1;
      // stb in cycle t+17, RESP in t+18: the clear lands on the edge that sets bit 3.
      wb_xfer(1'b1, 32'hC, 32'h8, 4'hF, rd, lat, ge, ga);
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h8) begin bad++; $display("FAIL collision_status got=%h want=8", rd); end
      total++; if (int_o !== 1'b1) begin bad++; $display("FAIL collision_int got=%b want=1", int_o); end
   endtask

   task automatic test_decode_err();
      logic [31:0] rd; int lat; logic ge, ga;
      wb_xfer(1'b1, 32'h14, 32'hFFFFFFFF, 4'hF, rd, lat, ge, ga);
      total++; if (ge !== 1'b1 || ga !== 1'b0 || lat !== 1) begin bad++; $display("FAIL err_resp got=err%b ack%b lat%0d want=err1 ack0 lat1", ge, ga, lat); end
      wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (ge !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_read got=err%b dat%h want=err1 dat0", ge, rd); end
      wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h8 || ga !== 1'b1) begin bad++; $display("FAIL err_nochange got=%h want=8", rd); end
   endtask

   task automatic test_back_to_back();
      logic exp_ack [4];
      exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1};
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h4; sel = 4'hF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++; if (ack !== exp_ack[k]) begin bad++; $display("FAIL b2b_ack cyc%0d got=%b want=%b", k, ack, exp_ack[k]); end
         if (exp_ack[k]) begin
            total++; if (dat_r !== 32'h8) begin bad++; $display("FAIL b2b_data cyc%0d got=%h want=8", k, dat_r); end
         end
      end
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [31:0] rd; int lat; logic ge, ga;
      total++; if (int_o !== 1'b1) begin bad++; $display("FAIL arst_pre_int got=%b want=1", int_o); end
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4; dat_w = 32'hF; sel = 4'hF;
      @(posedge clk); #2;
      total++; if (ack !== 1'b1) begin bad++; $display("FAIL arst_in_resp got=%b want=1", ack); end
      rstn = 1'b0;
      #1;
      total++; if (ack !== 1'b0 || int_o !== 1'b0) begin bad++; $display("FAIL arst_drop got=ack%b int%b want=ack0 int0", ack, int_o); end
      #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk) rstn = 1'b1;
      wb_xfer(1'b0, 32'h4, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0 || lat !== 1) begin bad++; $display("FAIL arst_ie got=%h lat%0d want=0 lat1", rd, lat); end
      wb_xfer(1'b0, 32'hC, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL arst_status got=%h want=0", rd); end
      wb_xfer(1'b0, 32'h8, 32'h0, 4'hF, rd, lat, ge, ga);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL arst_edge got=%h want=0", rd); end
   endtask

   initial begin
      test_reset();
      test_rising();
      test_glitch();
      test_fall_mask();
      test_collision();
      test_decode_err();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
